// File: rtl/data_mem_responder.sv
// Multi-cycle byte-addressable load/store memory behind valid/ready request and response channels.
// Define DMEM_STATS_EN to add the ld_count/st_count/err_count response counters.
module data_mem_responder #(
   parameter int MEM_BYTES = 256,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0] ld_count,
   output logic [31:0] st_count,
   output logic [31:0] err_count
`endif
);

   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        req_ready_q, rsp_valid_q, err_q;
   logic        write_q, uns_q;
   logic [1:0]  size_q;
   logic [63:0] addr_q, wdata_q, rdata_q;

   logic [7:0]  mem [MEM_BYTES];

   logic        req_fire, rsp_fire, enter_resp;
   logic        acc_write, acc_uns, err_d;
   logic [1:0]  acc_size;
   logic [63:0] acc_addr, acc_wdata, size_bytes, raw, rdata_d;
   logic [AW-1:0] base;

   assign req_fire   = req_valid & req_ready_q;
   assign rsp_fire   = rsp_valid_q & rsp_ready;
   assign enter_resp = (req_fire && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 4'd0));

   // In IDLE the access is taken straight from the port so a LATENCY of 1 can commit on the accept edge.
   assign acc_write = (state_q == IDLE) ? req_write    : write_q;
   assign acc_uns   = (state_q == IDLE) ? req_unsigned : uns_q;
   assign acc_size  = (state_q == IDLE) ? req_size     : size_q;
   assign acc_addr  = (state_q == IDLE) ? req_addr     : addr_q;
   assign acc_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;
   assign base      = acc_addr[AW-1:0];

   always_comb begin
      size_bytes = 64'd1 << acc_size;
      err_d = ((acc_addr & (size_bytes - 64'd1)) != 64'd0) ||
              (acc_addr > (64'(MEM_BYTES) - size_bytes));
      raw = '0;
      for (int i = 0; i < 8; i++) begin
         raw[8*i +: 8] = mem[base + AW'(i)];
      end
      rdata_d = '0;
      case (acc_size)
         2'd0:    rdata_d = {{56{raw[7]  & ~acc_uns}}, raw[7:0]};
         2'd1:    rdata_d = {{48{raw[15] & ~acc_uns}}, raw[15:0]};
         2'd2:    rdata_d = {{32{raw[31] & ~acc_uns}}, raw[31:0]};
         default: rdata_d = raw;
      endcase
      if (acc_write || err_d) begin
         rdata_d = '0;
      end
   end

   // Storage has no reset; a store lands only on the edge that enters RESP.
   always_ff @(posedge clk) begin
      if (enter_resp && acc_write && !err_d) begin
         for (int i = 0; i < 8; i++) begin
            if (i < (1 << acc_size)) begin
               mem[base + AW'(i)] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         write_q     <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_fire) begin
                  req_ready_q <= 1'b0;
                  write_q     <= req_write;
                  uns_q       <= req_unsigned;
                  size_q      <= req_size;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  cnt_q       <= 4'(LATENCY - 1);
                  if (LATENCY == 1) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rdata_q     <= rdata_d;
                     err_q       <= err_d;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rdata_q     <= rdata_d;
                  err_q       <= err_d;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (rsp_fire) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

`ifdef DMEM_STATS_EN
   logic [31:0] ld_cnt_q, st_cnt_q, err_cnt_q;

   // Faulting accesses still count as a load or store as well as an error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_cnt_q  <= '0;
         st_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else if (rsp_fire) begin
         if (write_q) begin
            st_cnt_q <= st_cnt_q + 32'd1;
         end else begin
            ld_cnt_q <= ld_cnt_q + 32'd1;
         end
         if (err_q) begin
            err_cnt_q <= err_cnt_q + 32'd1;
         end
      end
   end

   assign ld_count  = ld_cnt_q;
   assign st_count  = st_cnt_q;
   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table plus scoreboard, backpressure and reset-abort sequences.
// Define DMEM_STATS_EN to also check the response counters.
module tb_data_mem_responder;

   localparam int MemBytes = 256;
   localparam int Latency  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        reqValid = 1'b0, reqReady, reqWrite = 1'b0, reqUnsigned = 1'b0;
   logic [63:0] reqAddr = '0, reqWdata = '0;
   logic [1:0]  reqSize = '0;
   logic        rspValid, rspReady = 1'b0, rspErr;
   logic [63:0] rspRdata;
`ifdef DMEM_STATS_EN
   logic [31:0] ldCount, stCount, errCount;
`endif

   typedef struct {
      logic        write;
      logic [63:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [63:0] wdata;
      logic [63:0] expRdata;
      logic        expErr;
   } vec_t;

   typedef struct {
      logic        write;
      logic [63:0] rdata;
      logic        err;
   } sb_t;

   sb_t expQ[$];
   vec_t vecs[24];
   int checks = 0;
   int failures = 0;
   int expLd = 0, expSt = 0, expErrCnt = 0;

   data_mem_responder #(.MEM_BYTES(MemBytes), .LATENCY(Latency)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (reqValid),
      .req_ready    (reqReady),
      .req_write    (reqWrite),
      .req_addr     (reqAddr),
      .req_size     (reqSize),
      .req_unsigned (reqUnsigned),
      .req_wdata    (reqWdata),
      .rsp_valid    (rspValid),
      .rsp_ready    (rspReady),
      .rsp_rdata    (rspRdata),
      .rsp_err      (rspErr)
`ifdef DMEM_STATS_EN
      ,
      .ld_count     (ldCount),
      .st_count     (stCount),
      .err_count    (errCount)
`endif
   );

   // Free-running clock, inputs driven and outputs sampled on the falling edge.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [63:0] a, input logic [1:0] s,
                               input logic u, input logic [63:0] wd, input logic [63:0] er,
                               input logic ee);
      vec_t v;
      v.write = w; v.addr = a; v.size = s; v.uns = u; v.wdata = wd;
      v.expRdata = er; v.expErr = ee;
      return v;
   endfunction

   task automatic checkStats(input string tag);
`ifdef DMEM_STATS_EN
      check({tag, "_ld_count"},  64'(ldCount),  64'(expLd));
      check({tag, "_st_count"},  64'(stCount),  64'(expSt));
      check({tag, "_err_count"}, 64'(errCount), 64'(expErrCnt));
`else
      checks += 0;
`endif
   endtask

   // Waits for acceptance, then pushes the expected response; returns on the negedge after the accept edge.
   task automatic applyStimulus(input vec_t v);
      int guard;
      @(negedge clk);
      reqValid = 1'b1; reqWrite = v.write; reqAddr = v.addr; reqSize = v.size;
      reqUnsigned = v.uns; reqWdata = v.wdata;
      guard = 0;
      while (reqReady !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("req_ready_wait", 64'(reqReady), 64'd1);
      expQ.push_back('{v.write, v.expRdata, v.expErr});
      @(negedge clk);
      reqValid = 1'b0; reqAddr = '1; reqWdata = '1; reqSize = 2'd3; reqWrite = ~v.write;
   endtask

   task automatic checkOutput(input string tag, input int hold);
      int cycles;
      sb_t e;
      cycles = 0;
      while (rspValid !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      check({tag, "_latency"}, 64'(cycles), 64'(Latency));
      check({tag, "_sb_empty"}, 64'(expQ.size() == 0), 64'd0);
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
      end else begin
         e = '{1'b0, 64'd0, 1'b0};
      end
      check({tag, "_rdata"}, rspRdata, e.rdata);
      check({tag, "_err"}, 64'(rspErr), 64'(e.err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 64'(rspValid), 64'd1);
         check({tag, "_hold_rdata"}, rspRdata, e.rdata);
         check({tag, "_hold_req_ready"}, 64'(reqReady), 64'd0);
      end
      rspReady = 1'b1;
      @(negedge clk);
      rspReady = 1'b0;
      if (e.write) expSt++; else expLd++;
      if (e.err) expErrCnt++;
      check({tag, "_turn_req_ready"}, 64'(reqReady), 64'd1);
      check({tag, "_turn_rsp_valid"}, 64'(rspValid), 64'd0);
   endtask

   task automatic checkResetValues(input string tag);
      check({tag, "_req_ready"}, 64'(reqReady), 64'd0);
      check({tag, "_rsp_valid"}, 64'(rspValid), 64'd0);
      check({tag, "_rsp_rdata"}, rspRdata, 64'd0);
      check({tag, "_rsp_err"}, 64'(rspErr), 64'd0);
      expLd = 0; expSt = 0; expErrCnt = 0;
      checkStats(tag);
   endtask

   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int guard;
      vecs[0]  = mk(1, 64'h10, 2'd3, 0, 64'h1122334455667788, 64'h0, 0);
      vecs[1]  = mk(0, 64'h10, 2'd3, 0, 64'h0, 64'h1122334455667788, 0);
      vecs[2]  = mk(0, 64'h10, 2'd0, 0, 64'h0, 64'hFFFFFFFFFFFFFF88, 0);
      vecs[3]  = mk(0, 64'h10, 2'd0, 1, 64'h0, 64'h0000000000000088, 0);
      vecs[4]  = mk(0, 64'h16, 2'd1, 0, 64'h0, 64'h0000000000001122, 0);
      vecs[5]  = mk(0, 64'h12, 2'd2, 0, 64'h0, 64'h0, 1);
      vecs[6]  = mk(1, 64'hF8, 2'd3, 0, 64'hCAFEBABEDEADBEEF, 64'h0, 0);
      vecs[7]  = mk(1, 64'h100, 2'd3, 0, 64'h0123456789ABCDEF, 64'h0, 1);
      vecs[8]  = mk(0, 64'hF8, 2'd3, 0, 64'h0, 64'hCAFEBABEDEADBEEF, 0);
      vecs[9]  = mk(0, 64'hFC, 2'd2, 0, 64'h0, 64'hFFFFFFFFCAFEBABE, 0);
      vecs[10] = mk(0, 64'hFC, 2'd2, 1, 64'h0, 64'h00000000CAFEBABE, 0);
      vecs[11] = mk(0, 64'hFE, 2'd1, 0, 64'h0, 64'hFFFFFFFFFFFFCAFE, 0);
      vecs[12] = mk(0, 64'hFF, 2'd0, 1, 64'h0, 64'h00000000000000CA, 0);
      vecs[13] = mk(0, 64'hFF, 2'd1, 0, 64'h0, 64'h0, 1);
      vecs[14] = mk(0, 64'h100, 2'd0, 1, 64'h0, 64'h0, 1);
      vecs[15] = mk(0, 64'hFFFFFFFFFFFFFFFE, 2'd1, 0, 64'h0, 64'h0, 1);
      vecs[16] = mk(1, 64'h11, 2'd0, 0, 64'hFFFFFFFFFFFFFFAB, 64'h0, 0);
      vecs[17] = mk(1, 64'h16, 2'd1, 0, 64'h123456789ABCBEEF, 64'h0, 0);
      vecs[18] = mk(0, 64'h10, 2'd3, 0, 64'h0, 64'hBEEF33445566AB88, 0);
      vecs[19] = mk(1, 64'h14, 2'd2, 0, 64'hFFFFFFFF80000001, 64'h0, 0);
      vecs[20] = mk(0, 64'h14, 2'd2, 0, 64'h0, 64'hFFFFFFFF80000001, 0);
      vecs[21] = mk(0, 64'h10, 2'd3, 1, 64'h0, 64'h800000015566AB88, 0);
      vecs[22] = mk(1, 64'hF9, 2'd3, 0, 64'h1111111111111111, 64'h0, 1);
      vecs[23] = mk(0, 64'hF8, 2'd3, 0, 64'h0, 64'hCAFEBABEDEADBEEF, 0);

      repeat (2) @(negedge clk);
      checkResetValues("por");
      reset = 1'b1;

      for (int i = 0; i < 24; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), 0);
      end

      applyStimulus(mk(0, 64'h10, 2'd3, 0, 64'h0, 64'h800000015566AB88, 0));
      checkOutput("backpressure", 5);

      applyStimulus(mk(1, 64'h20, 2'd0, 0, 64'h55, 64'h0, 0));
      checkOutput("prestore", 0);

      // Abort a store while it is still waiting; it must never reach memory.
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 64'h20; reqSize = 2'd0; reqWdata = 64'hAA;
      guard = 0;
      while (reqReady !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("abort_req_ready_wait", 64'(reqReady), 64'd1);
      @(negedge clk);
      reqValid = 1'b0;
      check("abort_in_wait", 64'(rspValid), 64'd0);
      reset = 1'b0;
      #1;
      checkResetValues("abort_wait");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      applyStimulus(mk(0, 64'h20, 2'd0, 1, 64'h0, 64'h55, 0));
      checkOutput("after_abort", 0);

      // Reset while the response is pending; the store has already committed.
      applyStimulus(mk(1, 64'h21, 2'd0, 0, 64'h77, 64'h0, 0));
      guard = 0;
      while (rspValid !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check("resp_reset_valid", 64'(rspValid), 64'd1);
      if (expQ.size() != 0) void'(expQ.pop_front());
      reset = 1'b0;
      #1;
      checkResetValues("abort_resp");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      applyStimulus(mk(0, 64'h21, 2'd0, 1, 64'h0, 64'h77, 0));
      checkOutput("committed", 0);
      applyStimulus(mk(0, 64'h20, 2'd0, 1, 64'h0, 64'h55, 0));
      checkOutput("neighbour", 0);
      applyStimulus(mk(1, 64'h22, 2'd0, 0, 64'h01, 64'h0, 0));
      checkOutput("stats_store", 0);
      applyStimulus(mk(0, 64'h22, 2'd2, 0, 64'h0, 64'h0, 1));
      checkOutput("stats_fault", 0);
      checkStats("stats_final");

      @(negedge clk);
      reset = 1'b0;
      #1;
      checkResetValues("final_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
